// File: rtl/sid_pkg.sv
// Shared types and helpers for the SID filter arithmetic datapath.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package sid;

    typedef logic signed [15:0] s16_t;
    typedef logic signed [23:0] s24_t;
    typedef logic signed [31:0] s32_t;
    typedef logic        [10:0] reg11_t;

    // Ladder ratio of the original 6581 silicon; the ladder lacks its termination resistor.
    localparam real R2_DIV_R_6581 = 2.20;
    localparam int  TERM_6581     = 0;

    // Parallel combination of two finite resistances.
    function automatic real par(input real x, input real y);
        return (x * y) / (x + y);
    endfunction

endpackage

// File: rtl/sid_r2r_dac.sv
// MOS6581 filter-cutoff DAC; build option SID_DAC_NONLINEAR_EN selects R-2R ladder ROM vs ideal.
// Latency: 1 cycle, vout at edge n+1 reflects vin sampled at edge n; async active-high reset clears it.
// Backpressure: none, a new code is accepted every cycle.
module sid_r2r_dac
    import sid::*;
#(
    parameter int  BITS     = 11,
    parameter real R2_DIV_R = 2.20,
    parameter int  TERM     = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] vin,
    output logic [BITS-1:0] vout
);

    localparam int FULL = (1 << BITS) - 1;

`ifdef SID_DAC_NONLINEAR_EN

    // Voltage contributed at the ladder output by bit k alone (unnormalised).
    // A missing termination is modelled as an open circuit (infinite Rn).
    function automatic real ladder_weight(input int k);
        real vn;
        real r;
        real r2;
        real rn;
        real i_n;
        bit  rn_inf;
        vn     = 1.0;
        r      = 1.0;
        r2     = R2_DIV_R;
        rn_inf = (TERM == 0);
        rn     = rn_inf ? 0.0 : r2;
        // Resistance looking down from bit k through all lower bits.
        for (int j = 0; j < k; j++) begin
            if (rn_inf) begin
                rn     = r + r2;
                rn_inf = 1'b0;
            end else begin
                rn = r + par(r2, rn);
            end
        end
        // Source node of bit k: driven through its own 2R leg.
        if (rn_inf) begin
            rn = r2;
        end else begin
            rn = par(r2, rn);
            vn = vn * rn / r2;
        end
        // Divide down through each higher rung towards the output.
        for (int j = k + 1; j < BITS; j++) begin
            rn  = rn + r;
            i_n = vn / rn;
            rn  = par(r2, rn);
            vn  = rn * i_n;
        end
        return vn;
    endfunction

    // Normalised, rounded, clamped output for one input code.
    function automatic logic [BITS-1:0] ladder_code(input int code);
        real wsum;
        real acc;
        real w;
        real x;
        int  q;
        wsum = 0.0;
        acc  = 0.0;
        for (int k = 0; k < BITS; k++) begin
            w    = ladder_weight(k);
            wsum = wsum + w;
            if (code[k]) begin
                acc = acc + w;
            end
        end
        x = (acc * real'(FULL)) / wsum + 0.5;
        q = $rtoi(x);
        if (q > FULL) begin
            q = FULL;
        end
        if (q < 0) begin
            q = 0;
        end
        return q[BITS-1:0];
    endfunction

    logic [BITS-1:0] rom [1 << BITS];

    // Every ROM word is a constant fixed at elaboration; no real arithmetic survives into hardware.
    for (genvar g = 0; g < (1 << BITS); g++) begin : g_rom
        localparam logic [BITS-1:0] ENTRY = ladder_code(g);
        assign rom[g] = ENTRY;
    end

    // Registered ROM lookup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vout <= '0;
        end else begin
            vout <= rom[vin];
        end
    end

`else

    // A ladder with no usable configuration has no meaningful output; hold zero so it is noticed.
    localparam bit CFG_OK = ((TERM == 0) || (TERM == 1)) && (R2_DIV_R > 0.0);

    // Ideal DAC: the code passes straight through one register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vout <= '0;
        end else begin
            vout <= CFG_OK ? vin : '0;
        end
    end

`endif

endmodule

// File: rtl/sid_muladd_dac.sv
// SID filter arithmetic: signed MAC o = c +/- a*b plus 6581 cutoff DAC (SID_DAC_NONLINEAR_EN picks ladder model).
// Latency: 1 cycle on both paths; async active-high reset zeroes both outputs and drops in-flight results.
// Backpressure: none, fully pipelined, operands accepted every cycle.
module sid_muladd_dac
    import sid::*;
#(
    parameter int  BITS     = 11,
    parameter real R2_DIV_R = 2.20,
    parameter int  TERM     = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  s32_t            c,
    input  logic            s,
    input  s16_t            a,
    input  s16_t            b,
    output s32_t            o,
    input  logic [BITS-1:0] vin,
    output logic [BITS-1:0] vout
);

    s32_t prod;
    s32_t sum;

    // 16x16 signed product always fits 32 bits, so no product truncation is possible.
    assign prod = s32_t'(a) * s32_t'(b);

    // Single add/subtract after the multiplier keeps this a plain DSP pre-register multiply-add; wraps mod 2^32.
    always_comb begin
        sum = c + prod;
        if (s) begin
            sum = c - prod;
        end
    end

    // Output register for the MAC result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o <= '0;
        end else begin
            o <= sum;
        end
    end

    sid_r2r_dac #(
        .BITS     (BITS),
        .R2_DIV_R (R2_DIV_R),
        .TERM     (TERM)
    ) u_dac (
        .clk  (clk),
        .rst  (rst),
        .vin  (vin),
        .vout (vout)
    );

endmodule

// File: tb/tb_sid_muladd_dac.sv
// Scoreboard bench for sid_muladd_dac: directed MAC vectors, full DAC code sweep, async reset.
// Latency: expects results one edge after issue.
// Backpressure: none; stimulus is issued back-to-back.
module tb_sid_muladd_dac;
    import sid::*;

    localparam int BITS = 11;
    localparam int FULL = (1 << BITS) - 1;

    typedef struct {
        logic [31:0]     o;
        logic [BITS-1:0] v;
        int              code;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    s32_t            c   = '0;
    logic            s   = 1'b0;
    s16_t            a   = '0;
    s16_t            b   = '0;
    s32_t            o;
    logic [BITS-1:0] vin = '0;
    logic [BITS-1:0] vout;

    int   checks = 0;
    int   errors = 0;
    logic issue  = 1'b0;
    exp_t sb[$];
    int   obs [1 << BITS];
    real  gw [BITS];

    always #5 clk = ~clk;

    sid_muladd_dac #(
        .BITS     (BITS),
        .R2_DIV_R (2.20),
        .TERM     (0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .c    (c),
        .s    (s),
        .a    (a),
        .b    (b),
        .o    (o),
        .vin  (vin),
        .vout (vout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d (0x%08h) expected=%0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // Golden ladder: each bit's source sees the Thevenin resistance of the rungs below it,
    // then is attenuated by every rung above on the way to the output.
    function automatic real gold_weight(input int k);
        real rdown;
        real v;
        real i_cur;
        bit  open_end;
        open_end = 1'b1;
        rdown    = 0.0;
        for (int j = 0; j < k; j++) begin
            rdown    = open_end ? (1.0 + 2.20) : (1.0 + (2.20 * rdown) / (2.20 + rdown));
            open_end = 1'b0;
        end
        v = 1.0;
        if (open_end) begin
            rdown = 2.20;
        end else begin
            rdown = (2.20 * rdown) / (2.20 + rdown);
            v     = rdown / 2.20;
        end
        for (int j = k + 1; j < BITS; j++) begin
            i_cur = v / (rdown + 1.0);
            rdown = (2.20 * (rdown + 1.0)) / (2.20 + rdown + 1.0);
            v     = rdown * i_cur;
        end
        return v;
    endfunction

    function automatic int gold_code(input int code);
        real tot;
        real sel;
        int  q;
        tot = 0.0;
        sel = 0.0;
        for (int k = 0; k < BITS; k++) begin
            tot += gw[k];
            if (((code >> k) & 1) == 1) sel += gw[k];
        end
        q = $rtoi(sel * 2047.0 / tot + 0.5);
        if (q > FULL) q = FULL;
        return q;
    endfunction

    function automatic logic [BITS-1:0] exp_vout(input int code);
        int r;
`ifdef SID_DAC_NONLINEAR_EN
        r = gold_code(code);
`else
        r = code;
`endif
        return r[BITS-1:0];
    endfunction

    // Issue one vector at the falling edge and record what must appear one edge later.
    // v_exp < 0 means take the DAC expectation from the model.
    task automatic drive(input logic [31:0] cv, input logic sv, input int av, input int bv,
                         input int code, input logic [31:0] o_exp, input int v_exp);
        exp_t e;
        logic [31:0] vtmp;
        @(negedge clk);
        c     = s32_t'(cv);
        s     = sv;
        a     = s16_t'(av);
        b     = s16_t'(bv);
        vtmp  = code;
        vin   = vtmp[BITS-1:0];
        issue = 1'b1;
        e.o    = o_exp;
        e.code = code;
        if (v_exp < 0) begin
            e.v = exp_vout(code);
        end else begin
            vtmp = v_exp;
            e.v  = vtmp[BITS-1:0];
        end
        sb.push_back(e);
    endtask

    // Monitor: one edge after an issued vector, pop the scoreboard and compare both outputs.
    initial begin
        exp_t e;
        logic v;
        forever begin
            @(posedge clk);
            v = issue && !rst;
            #1;
            if (v) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow got=empty expected=entry");
                end else begin
                    e = sb.pop_front();
                    check("mac_o", o, e.o);
                    check("dac_vout", {21'd0, vout}, {21'd0, e.v});
                    obs[e.code] = int'(vout);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int   cv;
        int   av;
        int   bv;
        int   ov;
        logic sv;
        exp_t dropped;

        for (int k = 0; k < BITS; k++) gw[k] = gold_weight(k);

        #2 rst = 1'b1;
        #1;
        check("reset_o", o, 32'd0);
        check("reset_vout", {21'd0, vout}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed MAC vectors with hand-computed results; DAC endpoints carried alongside.
        drive(32'd0,        1'b1, 16383,  -32768, 0,      32'd536838144, 0);
        drive(32'd100,      1'b0, -2,     3,      2047,   32'd94,        2047);
        drive(32'hFFFFFFFF, 1'b1, -32768, -32768, 'h3FF,  32'hBFFFFFFF,  -1);
        drive(32'h7FFFFFFF, 1'b0, 1,      1,      'h400,  32'h80000000,  -1);
        drive(32'h80000000, 1'b1, 1,      1,      1,      32'h7FFFFFFF,  -1);
        drive(32'd0,        1'b0, 32767,  32767,  2,      32'h3FFF0001,  -1);

        // Back-to-back sweep of every DAC code with a varying MAC operand set.
        for (int i = 0; i <= FULL; i++) begin
            cv = i * 1000 - 7;
            sv = i[0];
            av = i - 1024;
            bv = 3 * i - 3000;
            ov = sv ? (cv - av * bv) : (cv + av * bv);
            drive(cv, sv, av, bv, i, ov, -1);
        end
        @(negedge clk);
        issue = 1'b0;
        repeat (2) @(negedge clk);
        check("sweep_drained", sb.size(), 32'd0);
`ifdef SID_DAC_NONLINEAR_EN
        check("nonmonotonic_carry", (obs['h400] < obs['h3FF]) ? 32'd1 : 32'd0, 32'd1);
`endif

        // Reset mid-stream: the vector in flight when rst rises must be discarded.
        drive(32'd5, 1'b0, 2, 3, 5, 32'd11, -1);
        drive(32'd9, 1'b0, 4, 4, 9, 32'd25, -1);
        #2;
        rst     = 1'b1;
        dropped = sb.pop_back();
        issue   = 1'b0;
        #1;
        check("async_reset_o", o, 32'd0);
        check("async_reset_vout", {21'd0, vout}, 32'd0);
        @(posedge clk);
        #1;
        check("held_reset_o", o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_o", o, 32'd0);
        check("post_reset_vout", {21'd0, vout}, 32'd0);
        drive(32'hFFFFFFF6, 1'b1, -5, 7, 77, 32'd25, -1);
        drive(32'd1, 1'b0, -1, 1, 2047, 32'd0, 2047);
        @(negedge clk);
        issue = 1'b0;
        repeat (3) @(negedge clk);
        check("final_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
